// File: rtl/pwm_ramp_pkg.sv
// pwm_ramp_pkg: shared register map, duty base address, CTRL/STATUS field positions and FSM state type
package pwm_ramp_pkg;
  localparam int A_CTRL = 0;
  localparam int A_TICK_DIV = 1;
  localparam int A_TARGET = 2;
  localparam int A_STEP = 8;
  localparam int A_STATUS = 16;
  localparam int A_CUR = 17;
  localparam int DUTY_BASE = 2;
  localparam int CTRL_EN_BIT = 0;
  localparam int CTRL_MASK_LSB = 8;
  localparam int STATUS_MISSED_BIT = 16;
  typedef enum logic {IDLE, SCAN} state_t;
endpackage

// File: rtl/pwm_ramp_if.sv
// pwm_ramp_if: host register bus (cs/read/write/reg_addr/wr_data/rd_data) and PWM core write bus
// (pwm_cs/pwm_write/pwm_reg_addr/pwm_wr_data); master = host/core side, slave = ramp controller
interface pwm_ramp_if;
  logic cs;
  logic read;
  logic write;
  logic [4:0] reg_addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic pwm_cs;
  logic pwm_write;
  logic [4:0] pwm_reg_addr;
  logic [31:0] pwm_wr_data;
  modport master (
    output cs, read, write, reg_addr, wr_data,
    input rd_data, pwm_cs, pwm_write, pwm_reg_addr, pwm_wr_data
  );
  modport slave (
    input cs, read, write, reg_addr, wr_data,
    output rd_data, pwm_cs, pwm_write, pwm_reg_addr, pwm_wr_data
  );
endinterface

// File: rtl/pwm_ramp_step.sv
// pwm_ramp_step: combinational saturating step of cur toward target
// ports: cur, target, step (in, W bits) -> next (out, W bits), never overshoots target
module pwm_ramp_step #(
  parameter int W = 10
) (
  input  logic [W-1:0] cur,
  input  logic [W-1:0] target,
  input  logic [W-1:0] step,
  output logic [W-1:0] next
);
  logic up;
  logic [W-1:0] gap;
  // comparing the remaining gap against step avoids any W-bit wrap of cur+/-step
  assign up = cur < target;
  assign gap = up ? target - cur : cur - target;
  assign next = (gap <= step) ? target : (up ? cur + step : cur - step);
endmodule

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: host-programmed duty-cycle ramp sequencer driving a PWM core register bus
// ports: clk; reset (sync, active-low); bus (pwm_ramp_if.slave: host register slave + core write master);
// irq (ramp-done interrupt, built only when PWM_RAMP_IRQ_EN is defined, else tied 0)
module pwm_ramp_ctrl
  import pwm_ramp_pkg::*;
#(
  parameter int NUM_CH = 6,
  parameter int RES_W = 10
) (
  input  logic clk,
  input  logic reset,
  pwm_ramp_if.slave bus,
  output logic irq
);
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  logic en;
  logic [NUM_CH-1:0] mask;
  logic [NUM_CH-1:0] busy;
  logic [31:0] tick_div;
  logic [31:0] cnt;
  logic [31:0] lim;
  logic [31:0] rd;
  logic [RES_W-1:0] tgt [NUM_CH];
  logic [RES_W-1:0] stp [NUM_CH];
  logic [RES_W-1:0] cur [NUM_CH];
  logic [RES_W-1:0] nxt;
  logic tick;
  logic missed;
  logic host_wr;
  logic status_wr;
  logic core_wr;
  logic unused_read;
  state_t state, state_n;
  logic [IW-1:0] idx, idx_n;
  assign host_wr = bus.cs && bus.write;
  assign status_wr = host_wr && bus.reg_addr == 5'(A_STATUS);
  assign unused_read = bus.read;
  // TICK_DIV of 0 divides like 1; >= keeps the counter bounded if TICK_DIV shrinks mid-count
  assign lim = (tick_div == '0) ? '0 : tick_div - 32'd1;
  assign tick = en && cnt >= lim;
  always_comb begin
    busy = '0;
    for (int i = 0; i < NUM_CH; i++) busy[i] = mask[i] && stp[i] != '0 && cur[i] != tgt[i];
  end
  pwm_ramp_step #(.W(RES_W)) u_step (
    .cur(cur[idx]),
    .target(tgt[idx]),
    .step(stp[idx]),
    .next(nxt)
  );
  always_comb begin
    state_n = state;
    idx_n = idx;
    core_wr = 1'b0;
    if (state == IDLE) begin
      state_n = tick ? SCAN : IDLE;
      idx_n = '0;
    end else if (!en) begin
      state_n = IDLE;
    end else begin
      core_wr = busy[idx];
      idx_n = idx + 1'b1;
      state_n = (idx == IW'(NUM_CH - 1)) ? IDLE : SCAN;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      en <= 1'b0;
      mask <= '0;
      tick_div <= '0;
      cnt <= '0;
      missed <= 1'b0;
      state <= IDLE;
      idx <= '0;
      bus.pwm_cs <= 1'b0;
      bus.pwm_write <= 1'b0;
      bus.pwm_reg_addr <= '0;
      bus.pwm_wr_data <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        tgt[i] <= '0;
        stp[i] <= '0;
        cur[i] <= '0;
      end
    end else begin
      cnt <= (!en || tick) ? '0 : cnt + 32'd1;
      state <= state_n;
      idx <= idx_n;
      bus.pwm_cs <= core_wr;
      bus.pwm_write <= core_wr;
      bus.pwm_reg_addr <= core_wr ? 5'(DUTY_BASE + int'(idx)) : '0;
      bus.pwm_wr_data <= core_wr ? 32'(nxt) : '0;
      if (core_wr) cur[idx] <= nxt;
      if (state == SCAN && tick) missed <= 1'b1;
      // host writes come last so a same-edge STATUS write clears a fresh miss and a jump overrides the scan
      if (status_wr) missed <= 1'b0;
      if (host_wr && bus.reg_addr == 5'(A_CTRL)) begin
        en <= bus.wr_data[CTRL_EN_BIT];
        mask <= bus.wr_data[CTRL_MASK_LSB +: NUM_CH];
      end
      if (host_wr && bus.reg_addr == 5'(A_TICK_DIV)) tick_div <= bus.wr_data;
      for (int i = 0; i < NUM_CH; i++) begin
        if (host_wr && bus.reg_addr == 5'(A_TARGET + i)) begin
          tgt[i] <= bus.wr_data[RES_W-1:0];
          if (bus.wr_data[31]) cur[i] <= bus.wr_data[RES_W-1:0];
        end
        if (host_wr && bus.reg_addr == 5'(A_STEP + i)) stp[i] <= bus.wr_data[RES_W-1:0];
      end
    end
  end
  always_comb begin
    rd = '0;
    if (bus.reg_addr == 5'(A_CTRL)) rd = (32'(en) << CTRL_EN_BIT) | (32'(mask) << CTRL_MASK_LSB);
    if (bus.reg_addr == 5'(A_TICK_DIV)) rd = tick_div;
    if (bus.reg_addr == 5'(A_STATUS)) rd = 32'(busy) | (32'(missed) << STATUS_MISSED_BIT);
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.reg_addr == 5'(A_TARGET + i)) rd = 32'(tgt[i]);
      if (bus.reg_addr == 5'(A_STEP + i)) rd = 32'(stp[i]);
      if (bus.reg_addr == 5'(A_CUR + i)) rd = 32'(cur[i]);
    end
  end
  assign bus.rd_data = rd;
`ifdef PWM_RAMP_IRQ_EN
  logic busy_q;
  logic irq_q;
  logic fall;
  // fall is high in the cycle right after busy drained, so irq is visible from that very edge
  assign fall = busy_q && busy == '0;
  assign irq = irq_q || fall;
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      busy_q <= |busy;
      irq_q <= status_wr ? 1'b0 : (irq_q || fall);
    end
  end
`else
  assign irq = 1'b0;
`endif
endmodule
